// File: rtl/cla_pipe_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adder_pkg
// Purpose : Shared types and helpers for the pipelined carry-lookahead
//           adder/subtractor (operation encoding, stage-count helper).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } add_op_t;

  // Number of lookahead groups, which is also the number of group stages.
  function automatic int ngrp(input int width, input int group);
    return width / group;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_pipe_adder_group.sv
`default_nettype none
// ============================================================================
// Module  : cla_group
// Purpose : Combinational GROUP-bit carry-lookahead block. Every internal
//           carry is a flat sum of products of generate/propagate terms, so
//           depth does not grow as a ripple chain.
// Ports   : a, b    [GROUP] operand slices
//           cin             carry into the group
//           sum     [GROUP] sum slice
//           cout            carry out of the group MSB
//           c_msb           carry into the group MSB
//           grp_p, grp_g    group propagate / group generate
// Rev     : 1.0  initial release
// ============================================================================
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             c_msb,
  output logic             grp_p,
  output logic             grp_g
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;
  logic             term;
  logic             acc;

  always_comb begin
    p     = a ^ b;
    g     = a & b;
    c     = '0;
    c[0]  = cin;
    term  = 1'b0;
    acc   = 1'b0;
    grp_g = 1'b0;
    // c[i+1] = OR over j<=i of (g[j] propagated through p[j+1..i])
    //          OR (cin propagated through p[0..i])
    for (int i = 0; i < GROUP; i++) begin
      acc = 1'b0;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) begin
          term = term & p[m];
        end
        acc = acc | term;
      end
      term = cin;
      for (int m = 0; m <= i; m++) begin
        term = term & p[m];
      end
      c[i+1] = acc | term;
    end
    grp_p = &p;
    for (int j = 0; j < GROUP; j++) begin
      term = g[j];
      for (int m = j + 1; m < GROUP; m++) begin
        term = term & p[m];
      end
      grp_g = grp_g | term;
    end
  end

  assign sum   = p ^ c[GROUP-1:0];
  assign cout  = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module  : cla_pipe_adder
// Purpose : Pipelined carry-lookahead adder/subtractor. An operand register
//           feeds NGRP skewed stages, each resolving one GROUP-bit group and
//           registering its carry, so the clock period is set by one group.
//           A single global stall holds every register when the output is
//           valid but not accepted.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           in_valid/in_ready        operand handshake
//           in_a, in_b [WIDTH]       operands
//           in_cin                   carry-in (add) / borrow-in (sub)
//           in_sub                   0: A+B+cin, 1: A-B-cin
//           out_valid/out_ready      result handshake
//           out_sum [WIDTH]          result
//           out_cout                 carry out (sub: 1 = no borrow)
//           out_ovf                  signed overflow
// Rev     : 1.0  initial release
// ============================================================================
module cla_pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NGRP = ngrp(WIDTH, GROUP);

  if (GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_bad_params
    $error("cla_pipe_adder: WIDTH must be a positive multiple of GROUP");
  end

  // Global stall: everything advances together or nothing moves.
  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Subtraction is A + ~B + ~cin so that borrows chain across words.
  add_op_t          op;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  assign op      = add_op_t'(in_sub);
  assign b_eff   = (op == OP_SUB) ? ~in_b : in_b;
  assign cin_eff = (op == OP_SUB) ? ~in_cin : in_cin;

  // Operand register (level 0 of the pipeline).
  logic             opv_d, opv_q;
  logic [WIDTH-1:0] opa_d, opa_q, opb_d, opb_q;
  logic             opc_d, opc_q;

  always_comb begin
    opv_d = in_valid;
    opa_d = in_a;
    opb_d = b_eff;
    opc_d = cin_eff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opv_q <= 1'b0;
      opa_q <= '0;
      opb_q <= '0;
      opc_q <= 1'b0;
    end else if (adv) begin
      opv_q <= opv_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      opc_q <= opc_d;
    end
  end

  // Per-stage register outputs, gathered so the next stage can reach them.
  logic             valid_q_arr [NGRP];
  logic             carry_q_arr [NGRP];
  logic             cmsb_q_arr  [NGRP];
  logic [WIDTH-1:0] sum_q_arr   [NGRP];
  logic [WIDTH-1:0] a_q_arr     [NGRP];
  logic [WIDTH-1:0] b_q_arr     [NGRP];

  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    localparam int LO = k * GROUP;

    logic [WIDTH-1:0] a_src, b_src, sum_src;
    logic             c_src, v_src;

    if (k == 0) begin : g_head
      assign a_src   = opa_q;
      assign b_src   = opb_q;
      assign sum_src = '0;
      assign c_src   = opc_q;
      assign v_src   = opv_q;
    end else begin : g_body
      assign a_src   = a_q_arr[k-1];
      assign b_src   = b_q_arr[k-1];
      assign sum_src = sum_q_arr[k-1];
      assign c_src   = carry_q_arr[k-1];
      assign v_src   = valid_q_arr[k-1];
    end

    logic [GROUP-1:0] grp_sum;
    logic             grp_cout, grp_cmsb, grp_p, grp_g;

    cla_group #(.GROUP(GROUP)) u_cla_group (
      .a     (a_src[LO +: GROUP]),
      .b     (b_src[LO +: GROUP]),
      .cin   (c_src),
      .sum   (grp_sum),
      .cout  (grp_cout),
      .c_msb (grp_cmsb),
      .grp_p (grp_p),
      .grp_g (grp_g)
    );

    // Group P/G are exported for future multi-level lookahead only.
    logic unused_pg;
    assign unused_pg = grp_p ^ grp_g;

    logic             valid_d, valid_q, carry_d, carry_q, cmsb_d, cmsb_q;
    logic [WIDTH-1:0] sum_d, sum_q;

    // Lower sum bits pass through; only this stage's group slice is new.
    always_comb begin
      valid_d            = v_src;
      carry_d            = grp_cout;
      cmsb_d             = grp_cmsb;
      sum_d              = sum_src;
      sum_d[LO +: GROUP] = grp_sum;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        cmsb_q  <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        cmsb_q  <= cmsb_d;
        sum_q   <= sum_d;
      end
    end

    assign valid_q_arr[k] = valid_q;
    assign carry_q_arr[k] = carry_q;
    assign cmsb_q_arr[k]  = cmsb_q;
    assign sum_q_arr[k]   = sum_q;

    // Operands only need to travel on while groups remain to be processed.
    if (k < NGRP - 1) begin : g_fwd
      logic [WIDTH-1:0] a_d, a_q, b_d, b_q;

      always_comb begin
        a_d = a_src;
        b_d = b_src;
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end

      assign a_q_arr[k] = a_q;
      assign b_q_arr[k] = b_q;
    end else begin : g_tail
      assign a_q_arr[k] = '0;
      assign b_q_arr[k] = '0;
    end
  end

  assign out_valid = valid_q_arr[NGRP-1];
  assign out_sum   = sum_q_arr[NGRP-1];
  assign out_cout  = carry_q_arr[NGRP-1];
  assign out_ovf   = cmsb_q_arr[NGRP-1] ^ carry_q_arr[NGRP-1];

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module  : tb_cla_pipe_adder
// Purpose : Self-checking bench for cla_pipe_adder (WIDTH=16, GROUP=4).
//           Arithmetic model plus FIFO scoreboard, hold-stability and
//           handshake checks, and directed literal vectors.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cla_pipe_adder;

  localparam int W   = 16;
  localparam int G   = 4;
  localparam int LAT = W / G;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Plain-arithmetic reference: unsigned sum for sum/cout, signed range
  // test for overflow.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   u;
    longint       ss;
    longint       smax;
    longint       smin;
    res_t         r;
    bb   = sub ? ~b : b;
    cc   = sub ? ~cin : cin;
    u    = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
    ss   = longint'($signed(a)) + longint'($signed(bb)) + longint'(cc);
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    r.sum  = u[W-1:0];
    r.cout = u[W];
    r.ovf  = (ss > smax) || (ss < smin);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Scoreboard / protocol monitor, sampled mid-cycle.
  res_t hold_r;
  logic hold_v = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        total++;
        if ({out_valid, out_sum, out_cout, out_ovf} !== {1'b1, hold_r}) begin
          bad++;
          $display("FAIL hold_stable: got v=%b %h/%b/%b want v=1 %h/%b/%b",
                   out_valid, out_sum, out_cout, out_ovf, hold_r.sum, hold_r.cout, hold_r.ovf);
        end
      end
      total++;
      if (in_ready !== (!out_valid || out_ready)) begin
        bad++;
        $display("FAIL in_ready_rule: got %b want %b", in_ready, (!out_valid || out_ready));
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL spurious_out: got sum %h want no result", out_sum);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          if ({out_sum, out_cout, out_ovf} !== e) begin
            bad++;
            $display("FAIL result: got %h/%b/%b want %h/%b/%b",
                     out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
      hold_v = out_valid && !out_ready;
      hold_r = '{sum: out_sum, cout: out_cout, ovf: out_ovf};
    end
  end

  task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input logic [W-1:0] es, input logic ec, input logic eo);
    res_t m;
    int   lat;
    m = model(a, b, cin, sub);
    chk({nm, "_model"}, {15'd0, m.sum, m.cout, m.ovf}, {15'd0, es, ec, eo});
    in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, LAT);
    chk({nm, "_sum"}, {16'd0, out_sum}, {16'd0, es});
    chk({nm, "_cout"}, {31'd0, out_cout}, {31'd0, ec});
    chk({nm, "_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic stream8();
    int sent = 0;
    int cyc  = 0;
    while (sent < 8 && cyc < 100) begin
      in_valid  = 1'b1;
      in_a      = W'(sent * 16'h1357);
      in_b      = W'(16'hFFF0 + sent);
      in_sub    = sent[0];
      in_cin    = sent[1];
      out_ready = !(cyc >= 6 && cyc < 9);
      @(negedge clk);
      chk("stream_in_ready", {31'd0, in_ready}, {31'd0, out_ready});
      if (in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_sent", sent, 8);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom());
    endcase
  endfunction

  initial begin
    int cnt;
    // Reset held with in_valid asserted.
    rst = 1'b1; in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", {16'd0, out_sum}, 32'd0);
    chk("rst_out_cout", {31'd0, out_cout}, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    cnt = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) cnt++; end
    chk("rst_no_output", cnt, 0);

    directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("sub_brw",  16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    directed("add_cin",  16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    directed("sub_bin",  16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);

    stream8();
    drain("stream_drain");

    // Flush three in-flight beats with a one-cycle reset.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = W'(16'h0100 * (i + 1)); in_b = 16'h0011; in_sub = 1'b0; in_cin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    cnt = 0;
    repeat (10) begin @(posedge clk); #1; if (out_valid) cnt++; end
    chk("flush_no_output", cnt, 0);

    // Random traffic with random back-pressure.
    repeat (10000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = pick();
      in_b      = pick();
      in_cin    = 1'($urandom_range(0, 1));
      in_sub    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
